// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array edge feeder.
package systolic_pkg;

    localparam int DEFAULT_N  = 4;
    localparam int DEFAULT_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WLOAD  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } feeder_state_t;

    // Lowest bit of lane `lane` inside a packed N*DW vector.
    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/feeder_skew_line.sv
// Fixed-depth shift register of {valid, data} tokens used to skew one array row.
module feeder_skew_line
    import systolic_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int DW    = DEFAULT_DW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic [DEPTH-1:0]         r_valid;
    logic [DEPTH-1:0][DW-1:0] r_data;

    // Bubbles shift exactly like real tokens, so every stage moves every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Edge driver for an N x N systolic array: loads the weight chain, then streams
// activations with a per-row skew so partial sums meet on the diagonal wavefront.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int DW = DEFAULT_DW
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            load_start,
    input  logic            stream_start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic            in_last,
    output logic [N*DW-1:0] win,
    output logic [N-1:0]    wwrite,
    output logic [N*DW-1:0] datain,
    output logic [N-1:0]    active,
    output logic            busy,
    output logic            done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    feeder_state_t   r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_in_ready;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_wwrite;
    logic [N*DW-1:0] r_win;

    logic            w_accept;
    logic            w_tok_valid;
    logic [N*DW-1:0] w_tok_data;

    assign w_accept    = in_valid && r_in_ready;
    assign w_tok_valid = (r_state == STREAM) && w_accept;
    assign w_tok_data  = w_tok_valid ? in_data : '0;

    // Handshake and status outputs are registered alongside the next state so
    // nothing downstream sees a combinational path from in_valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wwrite   <= '0;
            r_win      <= '0;
        end else begin
            r_done   <= 1'b0;
            r_wwrite <= '0;
            case (r_state)
                IDLE: begin
                    if (load_start) begin
                        r_state    <= WLOAD;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (stream_start) begin
                        r_state    <= STREAM;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                WLOAD: begin
                    if (w_accept) begin
                        r_win    <= in_data;
                        r_wwrite <= '1;
                        if (r_cnt == CW'(N - 1)) begin
                            r_state    <= IDLE;
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (w_accept && in_last) begin
                        r_in_ready <= 1'b0;
                        if (N > 1) begin
                            r_state <= DRAIN;
                            r_cnt   <= CW'(N - 2);
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Hold off until the last beat has reached the bottom row's output.
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_lane
            feeder_skew_line #(
                .DEPTH(i + 1),
                .DW   (DW)
            ) u_skew (
                .clock  (clock),
                .reset_n(reset_n),
                .i_valid(w_tok_valid),
                .i_data (w_tok_data[lane_lsb(i, DW) +: DW]),
                .o_valid(active[i]),
                .o_data (datain[lane_lsb(i, DW) +: DW])
            );
        end
    endgenerate

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wwrite   = r_wwrite;
    assign win      = r_win;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: weight load, skewed stream, reset abort, N=1 build.
module tb_systolic_feeder;

    logic        clock;
    logic        reset_n;

    logic        load_start;
    logic        stream_start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] win;
    logic [3:0]  wwrite;
    logic [31:0] datain;
    logic [3:0]  active;
    logic        busy;
    logic        done;

    logic        u1LoadStart;
    logic        u1StreamStart;
    logic        u1InValid;
    logic        u1InReady;
    logic [7:0]  u1InData;
    logic        u1InLast;
    logic [7:0]  u1Win;
    logic [0:0]  u1Wwrite;
    logic [7:0]  u1Datain;
    logic [0:0]  u1Active;
    logic        u1Busy;
    logic        u1Done;

    int assertions;
    int failures;

    systolic_feeder #(.N(4), .DW(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_start  (load_start),
        .stream_start(stream_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .win         (win),
        .wwrite      (wwrite),
        .datain      (datain),
        .active      (active),
        .busy        (busy),
        .done        (done)
    );

    systolic_feeder #(.N(1), .DW(8)) dutN1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_start  (u1LoadStart),
        .stream_start(u1StreamStart),
        .in_valid    (u1InValid),
        .in_ready    (u1InReady),
        .in_data     (u1InData),
        .in_last     (u1InLast),
        .win         (u1Win),
        .wwrite      (u1Wwrite),
        .datain      (u1Datain),
        .active      (u1Active),
        .busy        (u1Busy),
        .done        (u1Done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ls, input logic ss, input logic v,
                                 input logic [31:0] d, input logic last);
        load_start   = ls;
        stream_start = ss;
        in_valid     = v;
        in_data      = d;
        in_last      = last;
        @(negedge clock);
    endtask

    initial begin
        assertions    = 0;
        failures      = 0;
        reset_n       = 1'b0;
        load_start    = 1'b0;
        stream_start  = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        u1LoadStart   = 1'b0;
        u1StreamStart = 1'b0;
        u1InValid     = 1'b0;
        u1InData      = '0;
        u1InLast      = 1'b0;

        @(negedge clock);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_wwrite", wwrite, 0);
        checkOutput("rst_win", win, 0);
        checkOutput("rst_active", active, 0);
        checkOutput("rst_datain", datain, 0);
        reset_n = 1'b1;

        $display("[TB] weight load with simultaneous starts");
        applyStimulus(1, 1, 0, 32'h0, 0);
        checkOutput("wl_in_ready", in_ready, 1);
        checkOutput("wl_busy", busy, 1);
        checkOutput("wl_wwrite_idle", wwrite, 0);
        applyStimulus(0, 1, 1, 32'h01010101, 0);
        checkOutput("wl_wwrite1", wwrite, 4'hF);
        checkOutput("wl_win1", win, 32'h01010101);
        checkOutput("wl_done1", done, 0);
        applyStimulus(0, 0, 1, 32'h02020202, 1);
        checkOutput("wl_wwrite2", wwrite, 4'hF);
        checkOutput("wl_win2", win, 32'h02020202);
        checkOutput("wl_busy2", busy, 1);
        applyStimulus(0, 0, 1, 32'h03030303, 0);
        checkOutput("wl_wwrite3", wwrite, 4'hF);
        checkOutput("wl_win3", win, 32'h03030303);
        checkOutput("wl_done3", done, 0);
        applyStimulus(0, 0, 1, 32'h04040404, 0);
        checkOutput("wl_wwrite4", wwrite, 4'hF);
        checkOutput("wl_win4", win, 32'h04040404);
        checkOutput("wl_done4", done, 1);
        checkOutput("wl_busy4", busy, 0);
        checkOutput("wl_in_ready4", in_ready, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("wl_wwrite_after", wwrite, 0);
        checkOutput("wl_win_hold", win, 32'h04040404);
        checkOutput("wl_done_after", done, 0);
        checkOutput("wl_busy_after", busy, 0);

        $display("[TB] stream of three vectors with one bubble");
        applyStimulus(0, 1, 0, 32'h0, 0);
        checkOutput("st_in_ready", in_ready, 1);
        checkOutput("st_busy", busy, 1);
        checkOutput("st_active0", active, 0);
        applyStimulus(0, 0, 1, 32'h13121110, 0);
        checkOutput("st_active_t1", active, 4'b0001);
        checkOutput("st_datain_t1", datain, 32'h00000010);
        applyStimulus(0, 0, 1, 32'h23222120, 0);
        checkOutput("st_active_t2", active, 4'b0011);
        checkOutput("st_datain_t2", datain, 32'h00001120);
        applyStimulus(0, 0, 0, 32'hDEADBEEF, 0);
        checkOutput("st_active_t3", active, 4'b0110);
        checkOutput("st_datain_t3", datain, 32'h00122100);
        applyStimulus(0, 0, 1, 32'h33323130, 1);
        checkOutput("st_active_t4", active, 4'b1101);
        checkOutput("st_datain_t4", datain, 32'h13220030);
        checkOutput("st_in_ready_drain", in_ready, 0);
        checkOutput("st_busy_drain", busy, 1);
        checkOutput("st_done_t4", done, 0);
        applyStimulus(0, 0, 1, 32'h77777777, 0);
        checkOutput("st_active_t5", active, 4'b1010);
        checkOutput("st_datain_t5", datain, 32'h23003100);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("st_active_t6", active, 4'b0100);
        checkOutput("st_datain_t6", datain, 32'h00320000);
        checkOutput("st_done_t6", done, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("st_active_t7", active, 4'b1000);
        checkOutput("st_datain_t7", datain, 32'h33000000);
        checkOutput("st_done_t7", done, 1);
        checkOutput("st_busy_t7", busy, 0);
        checkOutput("st_wwrite_stream", wwrite, 0);

        $display("[TB] restart in done cycle, then reset mid-stream");
        applyStimulus(0, 1, 0, 32'h0, 0);
        checkOutput("rs_busy", busy, 1);
        checkOutput("rs_in_ready", in_ready, 1);
        checkOutput("rs_done", done, 0);
        checkOutput("rs_active", active, 0);
        applyStimulus(0, 0, 1, 32'h43424140, 0);
        applyStimulus(0, 0, 1, 32'h53525150, 0);
        checkOutput("rs_active_pre", active, 4'b0011);
        checkOutput("rs_datain_pre", datain, 32'h00004150);
        in_valid = 1'b0;
        in_data  = '0;
        reset_n  = 1'b0;
        #1;
        checkOutput("ra_active", active, 0);
        checkOutput("ra_datain", datain, 0);
        checkOutput("ra_busy", busy, 0);
        checkOutput("ra_in_ready", in_ready, 0);
        checkOutput("ra_done", done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("ra_busy_release", busy, 0);
        checkOutput("ra_done_release", done, 0);
        applyStimulus(0, 1, 0, 32'h0, 0);
        checkOutput("ra_busy_restart", busy, 1);
        applyStimulus(0, 0, 1, 32'h63626160, 1);
        checkOutput("ra_active_t1", active, 4'b0001);
        checkOutput("ra_datain_t1", datain, 32'h00000060);
        checkOutput("ra_in_ready_t1", in_ready, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("ra_datain_t2", datain, 32'h00006100);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("ra_active_t3", active, 4'b0100);
        checkOutput("ra_done_t3", done, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("ra_active_t4", active, 4'b1000);
        checkOutput("ra_datain_t4", datain, 32'h63000000);
        checkOutput("ra_done_t4", done, 1);

        $display("[TB] N=1 build");
        u1StreamStart = 1'b1;
        @(negedge clock);
        checkOutput("n1_in_ready", u1InReady, 1);
        checkOutput("n1_busy", u1Busy, 1);
        u1StreamStart = 1'b0;
        u1InValid     = 1'b1;
        u1InData      = 8'h5A;
        u1InLast      = 1'b1;
        @(negedge clock);
        checkOutput("n1_active", u1Active, 1);
        checkOutput("n1_datain", u1Datain, 8'h5A);
        checkOutput("n1_done", u1Done, 1);
        checkOutput("n1_busy_done", u1Busy, 0);
        checkOutput("n1_in_ready_done", u1InReady, 0);
        u1InValid = 1'b0;
        u1InLast  = 1'b0;
        u1InData  = '0;
        @(negedge clock);
        checkOutput("n1_active_after", u1Active, 0);
        checkOutput("n1_done_after", u1Done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
